token_drop_ctrl: RTL and testbench
==================================

Name: token_drop_ctrl

Overview:
- Sequences a single token drop on the 6x7 Connect-4 board.
- Accepts a move request (pulse plus column), checks the column is not full, then animates the token falling one row per tick.
- Reports the landing cell with a one-cycle token_ready pulse that drives the board-update/turn logic.
- Sits between the switch-decoding game logic (player_move, column_index) and the board registers/LED display. Rejects any new request while a drop is in flight.

Parameters:
- ROWS, 6, number of board rows; row 0 is the top, row ROWS-1 the bottom.
- COLS, 7, number of playable columns; column c maps to board bit index 15-c.
- TICK_DIV, 25000000, clock cycles per one-row fall step; minimum 1.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- player_move  input  1  one-cycle move request
- column_index  input  3  requested column, sampled with player_move
- game_over  input  1  while high, requests are ignored
- board_red  input  [5:0][15:0]  red occupancy, row-major
- board_grn  input  [5:0][15:0]  green occupancy, row-major
- token_ready  output  1  one-cycle pulse: token has landed
- final_row  output  3  landing row, valid while token_ready=1, held afterwards
- final_column  output  3  landing column, valid while token_ready=1, held afterwards
- anim_active  output  1  high while the falling token should be drawn
- anim_row  output  3  current row of the falling token
- anim_col  output  3  column of the falling token
- busy  output  1  high in FALL and LAND
- drop_error  output  1  one-cycle pulse: request rejected because the column is full

Behaviour:
- Occupancy: occ(r,c) = board_red[r][15-c] | board_grn[r][15-c]. Sampled live; the board is static during a drop.
- FSM states: IDLE, FALL, LAND.
- Reset: state=IDLE. All outputs 0, including final_row, final_column, anim_row and anim_col. The tick counter is cleared. Reset in any state aborts the drop immediately, with no token_ready pulse.
- IDLE, request accepted: player_move=1, game_over=0, column_index<COLS.
  - If occ(0,col)=1: pulse drop_error for the next cycle and stay in IDLE.
  - Otherwise latch col into anim_col, set anim_row=0, anim_active=1, load tick counter with TICK_DIV-1, and go to FALL.
- IDLE, ignored requests: player_move while game_over=1, or with column_index>=COLS (including 7), has no effect and does not pulse drop_error.
- FALL: the counter decrements each cycle. When the counter is 0 (tick):
  - If anim_row==ROWS-1 or occ(anim_row+1,col)=1: go to LAND.
  - Otherwise anim_row+1 and reload the counter with TICK_DIV-1.
- LAND (exactly one cycle):
  - token_ready=1, final_row=anim_row, final_column=anim_col.
  - Next cycle: go to IDLE with anim_active=0. final_row and final_column are held.
- Latency: landing row r gives token_ready high (r+1)*TICK_DIV+1 cycles after the player_move cycle.
- busy=1 in FALL and LAND. Any player_move while busy is dropped, not queued, including one in the LAND cycle.
- game_over rising during FALL does not abort; the drop completes normally.
- TICK_DIV=1: one row per cycle, and the counter is always 0.
- Counter width: $clog2(TICK_DIV+1). No wrap: the counter is always reloaded before underflow.
- drop_error and token_ready are never high in the same cycle.

Test Plan:
1. Empty board, TICK_DIV=4, player_move with column_index=3 at cycle 0 -> busy from cycle 1; anim_row steps 0..5 every 4 cycles; token_ready pulses at cycle 25 with final_row=5, final_column=3; anim_active=0 at cycle 26.
2. board_red[5][12]=1 and board_grn[4][12]=1 (column 3 holds 2 tokens), drop in column 3 -> final_row=3; token_ready at cycle 17.
3. Column 0 full (board bits [r][15]=1 for all r), request column 0 -> drop_error high for exactly 1 cycle; busy and token_ready stay 0; state remains IDLE.
4. Second player_move (column 1) issued mid-FALL and again in the LAND cycle -> both ignored; only one token_ready, for the original column.
5. Reset asserted during FALL at anim_row=2 -> next cycle all outputs 0; no token_ready; a new request afterwards starts again from row 0.
6. game_over=1 with player_move, column 2 -> no response; column_index=7 with player_move -> no response and no drop_error; TICK_DIV=1, empty column -> token_ready 7 cycles after the request.

Source files
------------

// File: rtl/token_drop_ctrl_if.sv
// Bundle between the game logic and the token drop sequencer.
// Game side (master) drives the move request and the board occupancy; the
// sequencer (slave) returns the landing report, animation state and status.
//   player_move   one-cycle move request
//   column_index  requested column, sampled with player_move
//   game_over     requests are ignored while high
//   board_red     red occupancy, row-major, row 0 at the top
//   board_grn     green occupancy, row-major
//   token_ready   one-cycle pulse when the token has landed
//   final_row     landing row (held after the pulse)
//   final_column  landing column (held after the pulse)
//   anim_active   falling token should be drawn
//   anim_row      current row of the falling token
//   anim_col      column of the falling token
//   busy          a drop is in flight
//   drop_error    one-cycle pulse, request rejected because column is full
interface token_drop_ctrl_if #(
  parameter int unsigned ROWS = 6
);
  logic                   player_move;
  logic [2:0]             column_index;
  logic                   game_over;
  logic [ROWS-1:0][15:0]  board_red;
  logic [ROWS-1:0][15:0]  board_grn;
  logic                   token_ready;
  logic [2:0]             final_row;
  logic [2:0]             final_column;
  logic                   anim_active;
  logic [2:0]             anim_row;
  logic [2:0]             anim_col;
  logic                   busy;
  logic                   drop_error;

  modport master (
    output player_move, column_index, game_over, board_red, board_grn,
    input  token_ready, final_row, final_column, anim_active, anim_row, anim_col,
           busy, drop_error
  );

  modport slave (
    input  player_move, column_index, game_over, board_red, board_grn,
    output token_ready, final_row, final_column, anim_active, anim_row, anim_col,
           busy, drop_error
  );
endinterface

// File: rtl/token_drop_ctrl.sv
// Sequences one token drop on the Connect-4 board: checks the requested
// column has room, steps the token down one row every TICK_DIV cycles until
// it rests on the bottom row or on another token, then pulses token_ready
// with the landing cell. Requests arriving while a drop is in flight are
// discarded.
// Ports:
//   clk    system clock
//   reset  synchronous, active-high; aborts any drop without a landing pulse
//   bus    token_drop_ctrl_if slave modport (request, board, results, status)
module token_drop_ctrl #(
  parameter int unsigned ROWS     = 6,
  parameter int unsigned COLS     = 7,
  parameter int unsigned TICK_DIV = 25000000
) (
  input logic              clk,
  input logic              reset,
  token_drop_ctrl_if.slave bus
);

  localparam int unsigned CW = $clog2(TICK_DIV + 1);
  localparam logic [CW-1:0] TICK_RELOAD = CW'(TICK_DIV - 1);
  localparam logic [2:0] LAST_ROW = 3'(ROWS - 1);
  localparam logic [3:0] NUM_COLS = 4'(COLS);

  typedef enum logic [1:0] {
    StIdle,
    StFall,
    StLand
  } state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic          token_ready_q;
  logic [2:0]    final_row_q;
  logic [2:0]    final_column_q;
  logic          anim_active_q;
  logic [2:0]    anim_row_q;
  logic [2:0]    anim_col_q;
  logic          busy_q;
  logic          drop_error_q;

  // Column c lives at board bit 15-c.
  function automatic logic [3:0] col_bit(input logic [2:0] c);
    return 4'd15 - {1'b0, c};
  endfunction

  logic       req_valid;
  logic       top_occ;
  logic [2:0] row_next;
  logic       below_occ;

  assign req_valid = bus.player_move && !bus.game_over && ({1'b0, bus.column_index} < NUM_COLS);
  assign top_occ   = bus.board_red[0][col_bit(bus.column_index)] |
                     bus.board_grn[0][col_bit(bus.column_index)];
  assign row_next  = anim_row_q + 3'd1;

  // Only look one row down when that row exists on the board.
  always_comb begin
    below_occ = 1'b0;
    if (anim_row_q != LAST_ROW) begin
      below_occ = bus.board_red[row_next][col_bit(anim_col_q)] |
                  bus.board_grn[row_next][col_bit(anim_col_q)];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      token_ready_q  <= 1'b0;
      final_row_q    <= 3'd0;
      final_column_q <= 3'd0;
      anim_active_q  <= 1'b0;
      anim_row_q     <= 3'd0;
      anim_col_q     <= 3'd0;
      busy_q         <= 1'b0;
      drop_error_q   <= 1'b0;
    end else begin
      token_ready_q <= 1'b0;
      drop_error_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            if (top_occ) begin
              drop_error_q <= 1'b1;
            end else begin
              anim_col_q    <= bus.column_index;
              anim_row_q    <= 3'd0;
              anim_active_q <= 1'b1;
              cnt_q         <= TICK_RELOAD;
              busy_q        <= 1'b1;
              state_q       <= StFall;
            end
          end
        end
        StFall: begin
          if (cnt_q == '0) begin
            if ((anim_row_q == LAST_ROW) || below_occ) begin
              state_q        <= StLand;
              token_ready_q  <= 1'b1;
              final_row_q    <= anim_row_q;
              final_column_q <= anim_col_q;
            end else begin
              anim_row_q <= row_next;
              cnt_q      <= TICK_RELOAD;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StLand: begin
          state_q       <= StIdle;
          anim_active_q <= 1'b0;
          busy_q        <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.token_ready  = token_ready_q;
  assign bus.final_row    = final_row_q;
  assign bus.final_column = final_column_q;
  assign bus.anim_active  = anim_active_q;
  assign bus.anim_row     = anim_row_q;
  assign bus.anim_col     = anim_col_q;
  assign bus.busy         = busy_q;
  assign bus.drop_error   = drop_error_q;

endmodule

// File: tb/tb_token_drop_ctrl.sv
// Directed bench for token_drop_ctrl: one instance with TICK_DIV=4 and one
// with TICK_DIV=1, sharing clock and reset.
module tb_token_drop_ctrl;

  logic clk;
  logic reset;

  int n_checks = 0;
  int n_fails  = 0;

  token_drop_ctrl_if #(.ROWS(6)) bus4 ();
  token_drop_ctrl_if #(.ROWS(6)) bus1 ();

  token_drop_ctrl #(.ROWS(6), .COLS(7), .TICK_DIV(4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4.slave)
  );

  token_drop_ctrl #(.ROWS(6), .COLS(7), .TICK_DIV(1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero4(input string tag);
    check({tag, "_ready"}, 32'(bus4.token_ready), 32'd0);
    check({tag, "_frow"},  32'(bus4.final_row), 32'd0);
    check({tag, "_fcol"},  32'(bus4.final_column), 32'd0);
    check({tag, "_act"},   32'(bus4.anim_active), 32'd0);
    check({tag, "_arow"},  32'(bus4.anim_row), 32'd0);
    check({tag, "_acol"},  32'(bus4.anim_col), 32'd0);
    check({tag, "_busy"},  32'(bus4.busy), 32'd0);
    check({tag, "_err"},   32'(bus4.drop_error), 32'd0);
  endtask

  // Drop in `col` on the TICK_DIV=4 instance, expecting landing row `row`.
  // Optionally inject column-1 requests at cycles inj_a/inj_b and raise
  // game_over at cycle go_at (0 disables each).
  task automatic drop4(input logic [2:0] col, input logic [2:0] row,
                       input int inj_a, input int inj_b, input int go_at);
    int land;
    int pulses;
    land   = (int'(row) + 1) * 4 + 1;
    pulses = 0;
    bus4.column_index = col;
    bus4.player_move  = 1'b1;
    step();
    bus4.player_move = 1'b0;
    for (int c = 1; c <= land + 1; c++) begin
      if (bus4.token_ready === 1'b1) pulses++;
      if (c < land) begin
        check("fall_busy",  32'(bus4.busy), 32'd1);
        check("fall_row",   32'(bus4.anim_row), 32'((c - 1) / 4));
        check("fall_col",   32'(bus4.anim_col), 32'(col));
        check("fall_ready", 32'(bus4.token_ready), 32'd0);
      end else if (c == land) begin
        check("land_ready", 32'(bus4.token_ready), 32'd1);
        check("land_row",   32'(bus4.final_row), 32'(row));
        check("land_col",   32'(bus4.final_column), 32'(col));
        check("land_act",   32'(bus4.anim_active), 32'd1);
        check("land_busy",  32'(bus4.busy), 32'd1);
      end else begin
        check("post_ready", 32'(bus4.token_ready), 32'd0);
        check("post_act",   32'(bus4.anim_active), 32'd0);
        check("post_busy",  32'(bus4.busy), 32'd0);
        check("post_frow",  32'(bus4.final_row), 32'(row));
        check("post_fcol",  32'(bus4.final_column), 32'(col));
      end
      if (c == inj_a || c == inj_b) begin
        bus4.column_index = 3'd1;
        bus4.player_move  = 1'b1;
      end
      if (c == go_at) bus4.game_over = 1'b1;
      step();
      bus4.player_move = 1'b0;
    end
    check("pulse_count", 32'(pulses), 32'd1);
    check("stay_idle", 32'(bus4.busy), 32'd0);
    bus4.game_over = 1'b0;
  endtask

  initial begin
    int pulses;
    reset = 1'b1;
    bus4.player_move = 1'b0; bus4.column_index = 3'd0; bus4.game_over = 1'b0;
    bus4.board_red = '0; bus4.board_grn = '0;
    bus1.player_move = 1'b0; bus1.column_index = 3'd0; bus1.game_over = 1'b0;
    bus1.board_red = '0; bus1.board_grn = '0;
    step();
    step();
    check_zero4("reset");
    check("reset1_busy", 32'(bus1.busy), 32'd0);
    check("reset1_ready", 32'(bus1.token_ready), 32'd0);
    reset = 1'b0;
    step();

    // Empty board, column 3: lands on row 5 at cycle 25.
    drop4(3'd3, 3'd5, 0, 0, 0);

    // Two tokens in column 3: lands on row 3 at cycle 17.
    bus4.board_red[5][12] = 1'b1;
    bus4.board_grn[4][12] = 1'b1;
    drop4(3'd3, 3'd3, 0, 0, 0);
    bus4.board_red = '0; bus4.board_grn = '0;

    // Full column 0 is rejected with a single drop_error pulse.
    for (int r = 0; r < 6; r++) begin
      if (r % 2 == 0) bus4.board_red[r][15] = 1'b1;
      else            bus4.board_grn[r][15] = 1'b1;
    end
    bus4.column_index = 3'd0;
    bus4.player_move  = 1'b1;
    step();
    bus4.player_move = 1'b0;
    check("full_err", 32'(bus4.drop_error), 32'd1);
    check("full_busy", 32'(bus4.busy), 32'd0);
    check("full_ready", 32'(bus4.token_ready), 32'd0);
    step();
    check("full_err_end", 32'(bus4.drop_error), 32'd0);
    for (int i = 0; i < 4; i++) begin
      check("full_idle_busy", 32'(bus4.busy), 32'd0);
      check("full_idle_act", 32'(bus4.anim_active), 32'd0);
      step();
    end
    bus4.board_red = '0; bus4.board_grn = '0;

    // Requests mid-FALL (cycle 10) and in the LAND cycle (25) are dropped.
    drop4(3'd5, 3'd5, 10, 25, 0);

    // game_over rising during FALL does not abort the drop.
    drop4(3'd4, 3'd5, 0, 0, 5);

    // Reset while falling at row 2 aborts with no landing pulse.
    bus4.column_index = 3'd2;
    bus4.player_move  = 1'b1;
    step();
    bus4.player_move = 1'b0;
    for (int c = 1; c < 10; c++) step();
    check("pre_reset_row", 32'(bus4.anim_row), 32'd2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_zero4("abort");
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      if (bus4.token_ready === 1'b1) pulses++;
      if (bus4.busy === 1'b1) pulses++;
      step();
    end
    check("abort_quiet", 32'(pulses), 32'd0);
    drop4(3'd2, 3'd5, 0, 0, 0);

    // Ignored requests: game_over, then column 7.
    bus4.game_over    = 1'b1;
    bus4.column_index = 3'd2;
    bus4.player_move  = 1'b1;
    step();
    bus4.player_move = 1'b0;
    check("go_busy", 32'(bus4.busy), 32'd0);
    check("go_err", 32'(bus4.drop_error), 32'd0);
    step();
    check("go_busy2", 32'(bus4.busy), 32'd0);
    bus4.game_over    = 1'b0;
    bus4.column_index = 3'd7;
    bus4.player_move  = 1'b1;
    step();
    bus4.player_move = 1'b0;
    check("c7_busy", 32'(bus4.busy), 32'd0);
    check("c7_err", 32'(bus4.drop_error), 32'd0);
    check("c7_act", 32'(bus4.anim_active), 32'd0);

    // TICK_DIV=1, empty column 6: token_ready 7 cycles after the request.
    bus1.column_index = 3'd6;
    bus1.player_move  = 1'b1;
    step();
    bus1.player_move = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      check("t1_ready", 32'(bus1.token_ready), (c == 7) ? 32'd1 : 32'd0);
      check("t1_busy", 32'(bus1.busy), (c <= 7) ? 32'd1 : 32'd0);
      if (c <= 6) check("t1_row", 32'(bus1.anim_row), 32'(c - 1));
      if (c == 7) begin
        check("t1_frow", 32'(bus1.final_row), 32'd5);
        check("t1_fcol", 32'(bus1.final_column), 32'd6);
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
